// File: rtl/aes_enc_sched_pkg.sv
// Shared constants and types for the AES-128 encryption scheduler.
// Block width, core latency and scheduler FSM state encoding.
package aes_enc_sched_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int AES_ENC_LAT = 11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
// Ports: req_i (requests), ptr_i (start index), gnt_o (one-hot), idx_o, any_o.
module aes_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW:0] c;
  logic         found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    any_o = |req_i;
    for (int i = 0; i < NREQ; i++) begin
      // ptr + i can exceed NREQ-1 once; fold it back (NREQ need not be 2^IDW)
      c = {1'b0, ptr_i} + (IDW+1)'(i);
      if (c >= (IDW+1)'(NREQ)) begin
        c = c - (IDW+1)'(NREQ);
      end
      if (!found && req_i[c[IDW-1:0]]) begin
        found = 1'b1;
        idx_o = c[IDW-1:0];
      end
    end
    if (found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_enc_sched.sv
// Round-robin scheduler sharing one iterative AES-128 core among NREQ ports.
// Ports: req_* (job in), core_* (core start/result), res_* (tagged out), busy_o, err_o.
module aes_enc_sched
  import aes_enc_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [NREQ-1:0]           req_v_i,
  input  logic [NREQ*AES_BLK_W-1:0] req_data_i,
  input  logic [NREQ*AES_BLK_W-1:0] req_key_i,
  output logic [NREQ-1:0]           req_rdy_o,
  output logic                      core_data_v_o,
  output logic [AES_BLK_W-1:0]      core_data_o,
  output logic [AES_BLK_W-1:0]      core_key_o,
  input  logic                      core_res_v_i,
  input  logic [AES_BLK_W-1:0]      core_res_i,
  output logic                      res_v_o,
  input  logic                      res_rdy_i,
  output logic [AES_BLK_W-1:0]      res_o,
  output logic [IDW-1:0]            res_id_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int CNTW = (TIMEOUT <= 16) ? 4 : $clog2(TIMEOUT);

  if (TIMEOUT <= AES_ENC_LAT) begin : g_bad_timeout
    $error("TIMEOUT must exceed the core latency");
  end

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]         rr_q, rr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic                   res_v_q, res_v_d;
  logic                   err_q, err_d;
  logic [AES_BLK_W-1:0]   res_q, res_d;
  logic [IDW-1:0]         res_id_q, res_id_d;

  logic [NREQ-1:0]        pick_gnt;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_any;
  logic                   out_free;
  logic                   pop;
  logic                   grant;

  aes_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (req_v_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign out_free = ~res_v_q | res_rdy_i;
  assign pop      = res_v_q & res_rdy_i;
  // no grant while reset is held, so req_rdy_o/strobe show reset values
  assign grant    = (state_q == IDLE) & pick_any & out_free & nreset;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      res_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      res_v_q <= res_v_d;
      err_q   <= err_d;
    end
  end

  // payload is qualified by res_v_q, so it carries no reset
  always_ff @(posedge clk) begin
    res_q    <= res_d;
    res_id_q <= res_id_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    id_d     = id_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    res_v_d  = res_v_q & ~pop;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (core_res_v_i) begin
          err_d = 1'b1;
        end
        if (grant) begin
          state_d = BUSY;
          id_d    = pick_idx;
          cnt_d   = '0;
          rr_d    = (pick_idx == IDW'(NREQ-1)) ?
                    '0 : pick_idx + IDW'(1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNTW'(1);
        if (core_res_v_i) begin
          res_d    = core_res_i;
          res_id_d = id_q;
          res_v_d  = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNTW'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_rdy_o     = grant ? pick_gnt : '0;
    core_data_v_o = grant;
    core_data_o   = req_data_i[pick_idx*AES_BLK_W +: AES_BLK_W];
    core_key_o    = req_key_i[pick_idx*AES_BLK_W +: AES_BLK_W];
    busy_o        = (state_q == BUSY);
    res_v_o       = res_v_q;
    res_o         = res_q;
    res_id_o      = res_id_q;
    err_o         = err_q;
  end

endmodule

// File: tb/tb_aes_enc_sched.sv
// Bench for aes_enc_sched: AES-128 core model, cycle scoreboard, directed + random.
// Drives inputs just after posedge, samples outputs at negedge.
module tb_aes_enc_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  nreset = 1'b0;
  logic [NREQ-1:0]       req_v_i = '0;
  logic [NREQ*128-1:0]   req_data_i = '0;
  logic [NREQ*128-1:0]   req_key_i = '0;
  logic [NREQ-1:0]       req_rdy_o;
  logic                  core_data_v_o;
  logic [127:0]          core_data_o;
  logic [127:0]          core_key_o;
  logic                  core_res_v_i = 1'b0;
  logic [127:0]          core_res_i = '0;
  logic                  res_v_o;
  logic                  res_rdy_i = 1'b1;
  logic [127:0]          res_o;
  logic [IDW-1:0]        res_id_o;
  logic                  busy_o;
  logic                  err_o;

  aes_enc_sched #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .req_v_i       (req_v_i),
    .req_data_i    (req_data_i),
    .req_key_i     (req_key_i),
    .req_rdy_o     (req_rdy_o),
    .core_data_v_o (core_data_v_o),
    .core_data_o   (core_data_o),
    .core_key_o    (core_key_o),
    .core_res_v_i  (core_res_v_i),
    .core_res_i    (core_res_i),
    .res_v_o       (res_v_o),
    .res_rdy_i     (res_rdy_i),
    .res_o         (res_o),
    .res_id_o      (res_id_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes(input logic [127:0] pt,
                                       input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [4];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      tmp = {w[3][23:0], w[3][31:24]};
      tmp = {sb[tmp[31:24]] ^ rc, sb[tmp[23:16]],
             sb[tmp[15:8]], sb[tmp[7:0]]};
      w[0] = w[0] ^ tmp;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = xt(rc);
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bench state ----------------
  bit              rand_mode = 0;
  bit              core_mute = 0;
  bit              spur = 0;
  logic [NREQ-1:0] keep = '0;

  // core model (owned by monitor)
  bit           cpend = 0;
  int           cpend_t = 0;
  logic [127:0] cpend_res = '0;

  // event records (owned by monitor, cleared by main)
  int           g_cyc [$];
  int           g_id  [$];
  int           r_cyc [$];
  int           r_id  [$];
  logic [127:0] r_val [$];
  int           pop_q [$];
  int           last_gnt_cyc = -10;
  int           last_gnt_w = 0;
  bit           prev_rv = 0;

  // transaction-level expectation of the scheduler
  bit           m_busy = 0;
  int           m_start = 0;
  int           m_id = 0;
  bit           m_buf_v = 0;
  logic [127:0] m_buf = '0;
  int           m_buf_id = 0;
  bit           m_err = 0;
  int           m_rr = 0;

  always @(negedge clk) begin : mon
    int  w, gi;
    bit  eg;
    w  = 0;
    gi = 0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_v_i[(m_rr+i)%NREQ]) w = (m_rr+i) % NREQ;
    eg = nreset && !m_busy && (req_v_i != '0) && (!m_buf_v || res_rdy_i);

    chk("busy", busy_o, m_busy);
    chk("err", err_o, m_err);
    chk("res_v", res_v_o, m_buf_v);
    if (m_buf_v) begin
      chk("res", res_o, m_buf);
      chk("res_id", res_id_o, m_buf_id);
    end
    chk("strobe", core_data_v_o, eg);
    chk("rdy", req_rdy_o, eg ? (1 << w) : 0);
    if (eg) begin
      chk("core_pt", core_data_o, req_data_i[w*128 +: 128]);
      chk("core_key", core_key_o, req_key_i[w*128 +: 128]);
      chk("core_idle", cpend, 0);
    end

    if (core_data_v_o) begin
      for (int i = 0; i < NREQ; i++) if (req_rdy_o[i]) gi = i;
      g_cyc.push_back(cyc);
      g_id.push_back(gi);
      last_gnt_cyc = cyc;
      last_gnt_w   = gi;
    end
    if (res_v_o && !prev_rv) begin
      r_cyc.push_back(cyc);
      r_id.push_back(int'(res_id_o));
      r_val.push_back(res_o);
    end
    prev_rv = res_v_o;
    if (res_v_o && res_rdy_i) pop_q.push_back(cyc);

    if (core_res_v_i && cpend && cyc == cpend_t + 11) cpend = 0;
    if (!nreset) cpend = 0;
    else if (core_data_v_o && !core_mute) begin
      cpend     = 1;
      cpend_t   = cyc;
      cpend_res = aes(core_data_o, core_key_o);
    end

    if (!nreset) begin
      m_busy = 0; m_buf_v = 0; m_err = 0; m_rr = 0;
    end else begin
      if (m_buf_v && res_rdy_i) m_buf_v = 0;
      if (m_busy) begin
        if (core_res_v_i) begin
          m_buf_v  = 1;
          m_buf    = core_res_i;
          m_buf_id = m_id;
          m_busy   = 0;
        end else if (cyc - m_start == TIMEOUT) begin
          m_err  = 1;
          m_busy = 0;
        end
      end else if (core_res_v_i) begin
        m_err = 1;
      end
      if (eg) begin
        m_busy  = 1;
        m_start = cyc;
        m_id    = w;
        m_rr    = (w + 1) % NREQ;
      end
    end
  end

  // one cycle: wait for the edge, then drive core model and requesters
  task automatic tick();
    @(posedge clk);
    #1;
    core_res_v_i = 1'b0;
    if (spur) begin
      core_res_v_i = 1'b1;
      core_res_i   = rnd128();
      spur         = 0;
    end else if (cpend && cyc == cpend_t + 11) begin
      core_res_v_i = 1'b1;
      core_res_i   = cpend_res;
    end
    if (rand_mode) begin
      req_v_i    = NREQ'($urandom);
      req_data_i = {rnd128(), rnd128(), rnd128(), rnd128()};
      req_key_i  = {rnd128(), rnd128(), rnd128(), rnd128()};
      res_rdy_i  = ($urandom_range(0, 3) != 0);
    end else if (last_gnt_cyc == cyc - 1) begin
      req_v_i[last_gnt_w] = keep[last_gnt_w];
      req_data_i[last_gnt_w*128 +: 128] = rnd128();
      req_key_i[last_gnt_w*128 +: 128]  = rnd128();
    end
  endtask

  task automatic do_reset();
    tick();
    nreset    = 1'b0;
    req_v_i   = '0;
    rand_mode = 0;
    keep      = '0;
    core_mute = 0;
    res_rdy_i = 1'b1;
    tick();
    tick();
    nreset = 1'b1;
    g_cyc.delete(); g_id.delete();
    r_cyc.delete(); r_id.delete(); r_val.delete();
    pop_q.delete();
  endtask

  task automatic wait_grants(input string tag, input int n, input int lim);
    int k = 0;
    while (g_cyc.size() < n && k < lim) begin tick(); k++; end
    if (g_cyc.size() < n) chk({tag, "_tmo"}, 0, 1);
  endtask

  task automatic wait_res(input string tag, input int n, input int lim);
    int k = 0;
    while (r_cyc.size() < n && k < lim) begin tick(); k++; end
    if (r_cyc.size() < n) chk({tag, "_tmo"}, 0, 1);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] pt, key, exp;
    int t0;
    build_sbox();

    // reset values, with requests pending during reset
    req_v_i = '1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_rdy", req_rdy_o, 0);
    chk("rst_strobe", core_data_v_o, 0);
    chk("rst_res_v", res_v_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);

    // FIPS-197 C.1 on requester 2
    do_reset();
    pt  = 128'h00112233445566778899aabbccddeeff;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    req_data_i[2*128 +: 128] = pt;
    req_key_i[2*128 +: 128]  = key;
    req_v_i = 4'b0100;
    wait_grants("fips_g", 1, 5);
    wait_res("fips_r", 1, 30);
    if (r_cyc.size() > 0 && g_cyc.size() > 0) begin
      chk("fips_ct", r_val[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("fips_id", r_id[0], 2);
      chk("fips_lat", r_cyc[0] - g_cyc[0], 12);
      chk("fips_one_strobe", g_cyc.size(), 1);
    end

    // all four requesters continuously valid
    do_reset();
    keep = '1;
    req_data_i = {rnd128(), rnd128(), rnd128(), rnd128()};
    req_key_i  = {rnd128(), rnd128(), rnd128(), rnd128()};
    req_v_i = '1;
    wait_grants("rr_g", 5, 100);
    wait_res("rr_r", 4, 30);
    if (g_cyc.size() >= 5 && r_cyc.size() >= 4) begin
      for (int i = 0; i < 5; i++) chk("rr_order", g_id[i], i % NREQ);
      for (int i = 0; i < 4; i++) chk("rr_space", g_cyc[i+1] - g_cyc[i], 12);
      for (int i = 0; i < 4; i++) chk("rr_res_id", r_id[i], i);
    end

    // backpressure on the output buffer
    do_reset();
    res_rdy_i = 1'b0;
    req_v_i   = 4'b0011;
    wait_res("bp_r", 1, 30);
    repeat (30) tick();
    @(negedge clk);
    chk("bp_nogrant", g_cyc.size(), 1);
    if (r_val.size() > 0) chk("bp_hold", res_o, r_val[0]);
    chk("bp_hold_id", res_id_o, 0);
    chk("bp_hold_v", res_v_o, 1);
    tick();
    res_rdy_i = 1'b1;
    wait_grants("bp_g", 2, 5);
    if (g_cyc.size() >= 2 && pop_q.size() > 0) begin
      chk("bp_grant_at_pop", g_cyc[1], pop_q[0]);
      chk("bp_g_id", g_id[1], 1);
    end
    wait_res("bp_r2", 2, 30);
    if (r_id.size() >= 2) chk("bp_r2_id", r_id[1], 1);

    // watchdog timeout: core never answers
    do_reset();
    core_mute = 1;
    req_v_i   = 4'b1000;
    wait_grants("tmo_g", 1, 5);
    t0 = (g_cyc.size() > 0) ? g_cyc[0] : cyc;
    while (cyc < t0 + TIMEOUT + 1) tick();
    @(negedge clk);
    chk("tmo_err", err_o, 1);
    chk("tmo_idle", busy_o, 0);
    chk("tmo_no_res", res_v_o, 0);
    tick();
    core_mute = 0;
    pt  = rnd128();
    key = rnd128();
    exp = aes(pt, key);
    req_data_i[1*128 +: 128] = pt;
    req_key_i[1*128 +: 128]  = key;
    req_v_i = 4'b0010;
    wait_grants("tmo_g2", 2, 5);
    if (g_id.size() >= 2) chk("tmo_g2_id", g_id[1], 1);
    wait_res("tmo_r", 1, 30);
    if (r_cyc.size() > 0) begin
      chk("tmo_res", r_val[0], exp);
      chk("tmo_res_id", r_id[0], 1);
    end

    // spurious core result while idle
    do_reset();
    spur = 1;
    tick();
    tick();
    @(negedge clk);
    chk("spur_err", err_o, 1);
    chk("spur_res_v", res_v_o, 0);

    // reset in the middle of a job
    do_reset();
    req_data_i[0 +: 128] = rnd128();
    req_v_i = 4'b0001;
    wait_grants("mid_g", 1, 5);
    t0 = (g_cyc.size() > 0) ? g_cyc[0] : cyc;
    while (cyc < t0 + 5) tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    @(negedge clk);
    chk("mid_res_v", res_v_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_err", err_o, 0);
    chk("mid_rdy", req_rdy_o, 0);
    chk("mid_strobe", core_data_v_o, 0);
    repeat (20) tick();
    chk("mid_no_res", r_cyc.size(), 0);
    pt  = rnd128();
    key = rnd128();
    exp = aes(pt, key);
    req_data_i[2*128 +: 128] = pt;
    req_key_i[2*128 +: 128]  = key;
    req_v_i = 4'b0100;
    wait_res("mid_r", 1, 30);
    if (r_cyc.size() > 0) begin
      chk("mid_res", r_val[0], exp);
      chk("mid_res_id", r_id[0], 2);
    end

    // random traffic with random backpressure
    do_reset();
    rand_mode = 1;
    repeat (400) tick();
    rand_mode = 0;
    req_v_i   = '0;
    res_rdy_i = 1'b1;
    repeat (30) tick();
    chk("rand_some_results", (r_cyc.size() > 5), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
